// File: rtl/linebuffer_ctrl.sv
// Read sequencer and window-valid tracker for a 3-row shifting line buffer.
// Walks IMG_H x IMG_W pixel memory one column per cycle, one band of KERNEL rows at a time.
module linebuffer_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int KERNEL = 3,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_r1_o,
  output logic [ADDR_W-1:0] rd_addr_r2_o,
  output logic [ADDR_W-1:0] rd_addr_r3_o,
  output logic              lb_wr_en_o,
  output logic              win_valid_o,
  output logic [IDX_W-1:0]  win_row_o,
  output logic [IDX_W-1:0]  win_col_o
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing reads, one column per non-held cycle
  // DRAIN | reads done, waiting for the final window to leave the pipeline
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0]  COL_LAST  = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0]  ROW_LAST  = IDX_W'(IMG_H - KERNEL);
  localparam logic [IDX_W-1:0]  WCOL_LAST = IDX_W'(IMG_W - KERNEL);
  localparam logic [IDX_W-1:0]  K_M1      = IDX_W'(KERNEL - 1);
  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(IMG_W);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  row_base_q, row_base_d;
  logic              lb_wr_q;
  logic [IDX_W-1:0]  col_p1_q, row_p1_q;
  logic              win_valid_q;
  logic [IDX_W-1:0]  win_row_q, win_col_q;
  logic              rd_en;
  logic              done;
  logic              in_run;
  logic [ADDR_W-1:0] base_a;

  assign in_run = (state_q == S_RUN);
  assign rd_en  = in_run && !hold_i;
  assign done   = win_valid_q && (win_row_q == ROW_LAST) && (win_col_q == WCOL_LAST);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          col_d      = '0;
          row_base_d = '0;
        end
      end
      S_RUN: begin
        if (!hold_i) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_base_q < ROW_LAST) row_base_d = row_base_q + 1'b1;
            else                       state_d    = S_DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1 tags memory data with its column; stage 2 masks the first KERNEL-1 columns of a band.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_base_q  <= '0;
      lb_wr_q     <= 1'b0;
      col_p1_q    <= '0;
      row_p1_q    <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_base_q  <= row_base_d;
      lb_wr_q     <= rd_en;
      col_p1_q    <= col_q;
      row_p1_q    <= row_base_q;
      win_valid_q <= lb_wr_q && (col_p1_q >= K_M1);
      win_row_q   <= row_p1_q;
      win_col_q   <= col_p1_q - K_M1;
    end
  end

  assign base_a = ADDR_W'(row_base_q) * W_A + ADDR_W'(col_q);

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done;
  assign rd_en_o      = rd_en;
  assign rd_addr_r1_o = in_run ? base_a             : '0;
  assign rd_addr_r2_o = in_run ? base_a + W_A       : '0;
  assign rd_addr_r3_o = in_run ? base_a + W_A + W_A : '0;
  assign lb_wr_en_o   = lb_wr_q;
  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Bench for linebuffer_ctrl: cycle schedule model, named-cycle table, pixel scoreboard.
module tb_linebuffer_ctrl;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int KERNEL = 3;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = 5;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NREAD  = (IMG_H - KERNEL + 1) * IMG_W;
  localparam int NWIN   = (IMG_H - KERNEL + 1) * (IMG_W - KERNEL + 1);
  localparam int MAXC   = 2048;

  logic clk_i = 1'b0;
  logic rst_i, start_i, hold_i;
  logic busy_o, done_o, rd_en_o, lb_wr_en_o, win_valid_o;
  logic [ADDR_W-1:0] rd_addr_r1_o, rd_addr_r2_o, rd_addr_r3_o;
  logic [IDX_W-1:0]  win_row_o, win_col_o;

  linebuffer_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hold_i(hold_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_r1_o(rd_addr_r1_o), .rd_addr_r2_o(rd_addr_r2_o), .rd_addr_r3_o(rd_addr_r3_o),
    .lb_wr_en_o(lb_wr_en_o), .win_valid_o(win_valid_o),
    .win_row_o(win_row_o), .win_col_o(win_col_o));

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int win_cnt = 0;
  bit chk_en = 0;

  logic [7:0] mem [NPIX];
  bit st_at [MAXC];
  bit hd_at [MAXC];
  bit rs_at [MAXC];
  bit e_busy [MAXC], e_done [MAXC], e_rd [MAXC], e_wr [MAXC], e_win [MAXC], e_av [MAXC];
  logic [ADDR_W-1:0] e_a1 [MAXC], e_a2 [MAXC], e_a3 [MAXC];
  logic [IDX_W-1:0]  e_row [MAXC], e_col [MAXC];
  logic [44:0] obs [MAXC];
  int done_cyc;

  typedef struct {
    int cyc;
    bit busy, done, rd, wr, win, chk_a;
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [IDX_W-1:0]  row, col;
  } vec_t;
  vec_t vt [15];

  function automatic logic [44:0] pack(input bit b, d, r, w, v,
      input logic [ADDR_W-1:0] a1, a2, a3, input logic [IDX_W-1:0] row, col);
    return {b, d, r, w, v, a1, a2, a3, row, col};
  endfunction

  function automatic vec_t mkv(input int c, input bit b, d, r, w, v, ca,
      input int a1, a2, a3, row, col);
    vec_t t;
    t.cyc = c; t.busy = b; t.done = d; t.rd = r; t.wr = w; t.win = v; t.chk_a = ca;
    t.a1 = ADDR_W'(a1); t.a2 = ADDR_W'(a2); t.a3 = ADDR_W'(a3);
    t.row = IDX_W'(row); t.col = IDX_W'(col);
    return t;
  endfunction

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Reference schedule: the k-th read lands on the k-th non-held cycle after start.
  function automatic void build(input int s);
    int k, c, last;
    k = 0; c = s + 1; last = s;
    while (k < NREAD && c < MAXC - 3) begin
      e_busy[c] = 1; e_av[c] = 1;
      e_a1[c] = ADDR_W'(((k / IMG_W) + 0) * IMG_W + k % IMG_W);
      e_a2[c] = ADDR_W'(((k / IMG_W) + 1) * IMG_W + k % IMG_W);
      e_a3[c] = ADDR_W'(((k / IMG_W) + 2) * IMG_W + k % IMG_W);
      if (!hd_at[c]) begin
        e_rd[c] = 1; e_wr[c+1] = 1;
        if (k % IMG_W >= KERNEL - 1) begin
          e_win[c+2] = 1;
          e_row[c+2] = IDX_W'(k / IMG_W);
          e_col[c+2] = IDX_W'(k % IMG_W - (KERNEL - 1));
        end
        last = c; k++;
      end
      c++;
    end
    e_busy[last+1] = 1; e_busy[last+2] = 1; e_done[last+2] = 1;
    done_cyc = last + 2;
  endfunction

  function automatic void clear_all();
    for (int c = 0; c < MAXC; c++) begin
      st_at[c] = 0; hd_at[c] = 0; rs_at[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_win[c] = 0; e_av[c] = 0;
      e_a1[c] = '0; e_a2[c] = '0; e_a3[c] = '0; e_row[c] = '0; e_col[c] = '0;
    end
  endfunction

  function automatic void clear_exp_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_win[c] = 0; e_av[c] = 0;
    end
  endfunction

  // Monitor: schedule compare, then line-buffer model (check, shift, capture in that order).
  logic [7:0] lb [3][3];
  logic [7:0] pend [3];
  always @(negedge clk_i) begin
    logic [44:0] act, expv;
    logic [71:0] ap, gp;
    int idx;
    if (cyc >= 0 && cyc < MAXC)
      obs[cyc] = pack(busy_o, done_o, rd_en_o, lb_wr_en_o, win_valid_o,
                      rd_addr_r1_o, rd_addr_r2_o, rd_addr_r3_o, win_row_o, win_col_o);
    if (chk_en && cyc >= 0 && cyc < MAXC) begin
      expv = pack(e_busy[cyc], e_done[cyc], e_rd[cyc], e_wr[cyc], e_win[cyc],
                  e_av[cyc] ? e_a1[cyc] : '0, e_av[cyc] ? e_a2[cyc] : '0, e_av[cyc] ? e_a3[cyc] : '0,
                  e_win[cyc] ? e_row[cyc] : '0, e_win[cyc] ? e_col[cyc] : '0);
      act  = pack(busy_o, done_o, rd_en_o, lb_wr_en_o, win_valid_o,
                  e_av[cyc] ? rd_addr_r1_o : '0, e_av[cyc] ? rd_addr_r2_o : '0,
                  e_av[cyc] ? rd_addr_r3_o : '0,
                  e_win[cyc] ? win_row_o : '0, e_win[cyc] ? win_col_o : '0);
      check("sched", {27'd0, act}, {27'd0, expv});
    end
    if (win_valid_o) begin
      win_cnt++;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          idx = (int'(win_row_o) + r) * IMG_W + int'(win_col_o) + c;
          gp[71 - 8*(3*r+c) -: 8] = (idx < NPIX) ? mem[idx] : 8'hxx;
          ap[71 - 8*(3*r+c) -: 8] = lb[r][c];
        end
      check("patch", ap, gp);
    end
    if (lb_wr_en_o)
      for (int r = 0; r < 3; r++) begin
        lb[r][0] = lb[r][1]; lb[r][1] = lb[r][2]; lb[r][2] = pend[r];
      end
    if (rd_en_o) begin
      pend[0] = (int'(rd_addr_r1_o) < NPIX) ? mem[rd_addr_r1_o] : 8'h00;
      pend[1] = (int'(rd_addr_r2_o) < NPIX) ? mem[rd_addr_r2_o] : 8'h00;
      pend[2] = (int'(rd_addr_r3_o) < NPIX) ? mem[rd_addr_r3_o] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1; cyc++;
  endtask

  task automatic run(input int len);
    cyc = 0; win_cnt = 0; chk_en = 1;
    for (int i = 0; i < len; i++) begin
      start_i = st_at[cyc]; hold_i = hd_at[cyc]; rst_i = rs_at[cyc];
      tick();
    end
    chk_en = 0; start_i = 0; hold_i = 0; rst_i = 0;
  endtask

  initial begin
    logic [44:0] ev, av;
    int dc, nd, s;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 3; r++) begin
      pend[r] = 0;
      for (int c = 0; c < 3; c++) lb[r][c] = 0;
    end
    rst_i = 1; start_i = 0; hold_i = 0;
    cyc = -10;
    repeat (3) tick();

    // cyc | busy done rd wr win chk_a | a1 a2 a3 | row col
    vt[0]  = mkv(0,   0,0,0,0,0,1,   0,  0,  0,  0, 0);
    vt[1]  = mkv(1,   1,0,1,0,0,1,   0, 28, 56,  0, 0);
    vt[2]  = mkv(2,   1,0,1,1,0,1,   1, 29, 57,  0, 0);
    vt[3]  = mkv(4,   1,0,1,1,0,1,   3, 31, 59,  0, 0);
    vt[4]  = mkv(5,   1,0,1,1,1,1,   4, 32, 60,  0, 0);
    vt[5]  = mkv(28,  1,0,1,1,1,1,  27, 55, 83,  0,23);
    vt[6]  = mkv(29,  1,0,1,1,1,1,  28, 56, 84,  0,24);
    vt[7]  = mkv(30,  1,0,1,1,1,1,  29, 57, 85,  0,25);
    vt[8]  = mkv(31,  1,0,1,1,0,1,  30, 58, 86,  0, 0);
    vt[9]  = mkv(32,  1,0,1,1,0,1,  31, 59, 87,  0, 0);
    vt[10] = mkv(33,  1,0,1,1,1,1,  32, 60, 88,  1, 0);
    vt[11] = mkv(728, 1,0,1,1,1,1, 727,755,783, 25,23);
    vt[12] = mkv(729, 1,0,0,1,1,0,   0,  0,  0, 25,24);
    vt[13] = mkv(730, 1,1,0,0,1,0,   0,  0,  0, 25,25);
    vt[14] = mkv(731, 0,0,0,0,0,0,   0,  0,  0,  0, 0);

    // Plain frame, start at cycle 0.
    clear_all(); st_at[0] = 1; build(0);
    run(735);
    check("win_count_plain", 72'(win_cnt), 72'(NWIN));
    for (int i = 0; i < 15; i++) begin
      bit ma, mw;
      ma = vt[i].chk_a || vt[i].rd;
      mw = vt[i].win;
      ev = pack(vt[i].busy, vt[i].done, vt[i].rd, vt[i].wr, vt[i].win,
                ma ? vt[i].a1 : '0, ma ? vt[i].a2 : '0, ma ? vt[i].a3 : '0,
                mw ? vt[i].row : '0, mw ? vt[i].col : '0);
      av = obs[vt[i].cyc];
      if (!ma) av[29:10] = '0;
      if (!ma) av[39:30] = '0;
      if (!mw) av[9:0]   = '0;
      cyc = vt[i].cyc;
      check("table", {27'd0, av}, {27'd0, ev});
    end

    // Hold for cycles 10..14 stretches the frame by five cycles.
    clear_all(); st_at[0] = 1;
    for (int c = 10; c <= 14; c++) hd_at[c] = 1;
    build(0);
    run(740);
    check("win_count_hold", 72'(win_cnt), 72'(NWIN));
    dc = -1;
    for (int c = 0; c < 740; c++) if (obs[c][43] && dc < 0) dc = c;
    check("done_cycle_hold", 72'(dc), 72'(735));

    // Start mid-frame is ignored; reset at 200 aborts with no done.
    clear_all(); st_at[0] = 1; build(0);
    st_at[100] = 1; rs_at[200] = 1; clear_exp_from(201);
    run(260);
    cyc = 201;
    check("reset_outputs", {27'd0, obs[201]}, 72'd0);
    nd = 0;
    for (int c = 0; c < 260; c++) if (obs[c][43]) nd++;
    check("abort_no_done", 72'(nd), 72'd0);

    // Fresh frame after the abort restarts from row 0, col 0.
    clear_all(); st_at[0] = 1; build(0);
    run(735);
    check("win_count_restart", 72'(win_cnt), 72'(NWIN));

    // Random hold patterns, stray starts while busy and a start coincident with done.
    for (int f = 0; f < 3; f++) begin
      clear_all();
      s = $urandom_range(0, 4);
      st_at[s] = 1;
      for (int c = s + 1; c < MAXC - 10; c++) hd_at[c] = ($urandom_range(0, 3) == 0);
      build(s);
      st_at[s + $urandom_range(20, 500)] = 1;
      st_at[done_cyc] = 1;
      run(done_cyc + 5);
      check("win_count_rand", 72'(win_cnt), 72'(NWIN));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
